// File: rtl/multi_freq_counter.sv
// multi_freq_counter: gated edge counter over CHANNELS async inputs with back-to-back windows
module multi_freq_counter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 24,
  parameter int GATE_CYCLES = 8000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [CHANNELS-1:0] freqin,
  input  logic enable,
  input  logic [1:0] edge_mode,
  output logic [CHANNELS*WIDTH-1:0] frequency,
  output logic [CHANNELS-1:0] overflow,
  output logic valid
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);
  logic [CHANNELS-1:0] s1, s2, s3, rise, fall, inc, hit, ovf;
  logic [1:0] arm, mode, msel;
  logic run, term;
  logic [GW-1:0] gc;
  logic [WIDTH-1:0] cnt [CHANNELS];
  logic [WIDTH-1:0] nxt [CHANNELS];
  // the first enabled cycle already belongs to a window using the incoming mode
  assign msel = (enable & ~run) ? edge_mode : mode;
  assign rise = s2 & ~s3 & {CHANNELS{&arm}};
  assign fall = ~s2 & s3 & {CHANNELS{&arm}};
  assign inc = msel == 2'b00 ? rise : msel == 2'b01 ? fall : msel == 2'b10 ? (rise | fall) : '0;
  assign term = enable & (gc == LAST);
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i] = (cnt[i] == MAX) & inc[i];
      nxt[i] = (cnt[i] == MAX) ? MAX : cnt[i] + WIDTH'(inc[i]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      arm <= '0;
    end else begin
      s1 <= freqin;
      s2 <= s1;
      s3 <= s2;
      arm <= arm + 2'(arm != 2'd3);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gc <= '0;
      run <= 1'b0;
      mode <= 2'b00;
      ovf <= '0;
      valid <= 1'b0;
      frequency <= '0;
      overflow <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else if (!enable) begin
      gc <= '0;
      run <= 1'b0;
      ovf <= '0;
      valid <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      run <= 1'b1;
      valid <= term;
      if (!run || term) mode <= edge_mode;
      gc <= term ? '0 : gc + 1'b1;
      ovf <= term ? '0 : (ovf | hit);
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= term ? '0 : nxt[i];
      if (term) begin
        overflow <= ovf | hit;
        for (int i = 0; i < CHANNELS; i++) frequency[i*WIDTH +: WIDTH] <= nxt[i];
      end
    end
  end
endmodule

// File: tb/tb_multi_freq_counter.sv
// tb_multi_freq_counter: directed checks on an 8-bit and a 4-bit counter sharing one stimulus
module tb_multi_freq_counter;
  logic clk = 0, rst_n = 0, enable = 0, f0 = 0, f1 = 0;
  logic [1:0] edge_mode = 2'b00;
  logic [3:0] freqin;
  logic [31:0] fa, ovfa, fb;
  logic [3:0] ovb, ovfb;
  logic [3:0] ova;
  logic va, vb;
  int n_vec = 0, n_err = 0, half = 0, ph = 0, n = 0, seen = 0;
  assign freqin = {2'b00, f1, f0};
  always #5 clk = ~clk;
  multi_freq_counter #(.CHANNELS(4), .WIDTH(8), .GATE_CYCLES(100)) u_a (
    .clk(clk), .rst_n(rst_n), .freqin(freqin), .enable(enable), .edge_mode(edge_mode),
    .frequency(fa), .overflow(ova), .valid(va));
  multi_freq_counter #(.CHANNELS(4), .WIDTH(4), .GATE_CYCLES(100)) u_b (
    .clk(clk), .rst_n(rst_n), .freqin(freqin), .enable(enable), .edge_mode(edge_mode),
    .frequency(fb[15:0]), .overflow(ovb), .valid(vb));
  assign fb[31:16] = '0;
  assign ovfa = {28'd0, ova};
  assign ovfb = ovb;
  always @(negedge clk) if (half != 0) begin
    ph++;
    if (ph >= half) begin
      ph = 0;
      f0 = ~f0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(input int lim, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!va && cyc < lim);
  endtask
  initial begin
    half = 5;
    f1 = 1;
    repeat (4) @(negedge clk);
    chk("rst_freq_a", fa, 0);
    chk("rst_ovf_a", ovfa, 0);
    chk("rst_valid_a", {31'd0, va}, 0);
    chk("rst_freq_b", fb, 0);
    chk("rst_valid_b", {31'd0, vb}, 0);
    rst_n = 1;
    enable = 1;
    wait_valid(200, n);
    chk("first_valid_lat", n, 100);
    chk("ch1_held_a", {24'd0, fa[15:8]}, 0);
    chk("ch1_held_b", {28'd0, fb[7:4]}, 0);
    wait_valid(200, n);
    chk("period_00", n, 100);
    chk("rise_a", fa, 32'd10);
    chk("rise_ovf_a", ovfa, 0);
    chk("rise_b", fb, 32'd10);
    chk("rise_ovf_b", {28'd0, ovfb}, 0);
    chk("valid_vb", {31'd0, vb}, 1);
    @(negedge clk);
    chk("valid_one_cycle", {31'd0, va}, 0);
    repeat (49) @(negedge clk);
    edge_mode = 2'b10;
    wait_valid(200, n);
    chk("mid_change_lat", n, 50);
    chk("mid_change_old", fa, 32'd10);
    wait_valid(200, n);
    chk("both_a", fa, 32'd20);
    chk("both_ovf_a", ovfa, 0);
    chk("both_b_sat", fb, 32'd15);
    chk("both_ovf_b", {28'd0, ovfb}, 32'd1);
    edge_mode = 2'b00;
    half = 2;
    wait_valid(200, n);
    wait_valid(200, n);
    chk("p4_a", fa, 32'd25);
    chk("p4_b_sat", fb, 32'd15);
    chk("p4_ovf_b", {28'd0, ovfb}, 32'd1);
    half = 10;
    wait_valid(200, n);
    wait_valid(200, n);
    chk("p20_a", fa, 32'd5);
    chk("p20_b", fb, 32'd5);
    chk("p20_ovf_b", {28'd0, ovfb}, 0);
    repeat (60) @(negedge clk);
    enable = 0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (va) seen++;
    end
    chk("gap_no_valid", seen, 0);
    chk("gap_hold_a", fa, 32'd5);
    chk("gap_hold_b", fb, 32'd5);
    enable = 1;
    wait_valid(200, n);
    chk("reenable_lat", n, 100);
    chk("reenable_a", fa, 32'd5);
    repeat (40) @(negedge clk);
    rst_n = 0;
    #1;
    chk("async_freq_a", fa, 0);
    chk("async_freq_b", fb, 0);
    chk("async_ovf_b", {28'd0, ovfb}, 0);
    chk("async_valid", {31'd0, va}, 0);
    @(negedge clk);
    rst_n = 1;
    wait_valid(200, n);
    chk("post_rst_lat", n, 100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/multi_freq_counter.md
# multi_freq_counter

Parametrised multi-channel frequency counter: the next generation of the single-channel gated counter. It counts edges on CHANNELS asynchronous inputs over a common gate window of GATE_CYCLES clocks. The window has no dead time, and the edge type is selectable. It publishes every window's results at once with a one-cycle valid strobe and a per-channel overflow flag. It sits between the external frequency inputs and the host-readable register block.

## Interface
- CHANNELS, 4: number of independent input channels (1..16)
- WIDTH, 24: count/result width per channel (2..32)
- GATE_CYCLES, 8000000: clk cycles per gate window (>= 4); gate counter width is $clog2(GATE_CYCLES)

- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- freqin  in  CHANNELS  asynchronous inputs to be measured
- enable  in  1  1 = run windows; 0 = idle/clear
- edge_mode  in  2  00 rising, 01 falling, 10 both edges, 11 channel counting disabled
- frequency  out  CHANNELS*WIDTH  last window's count; channel i at bits [i*WIDTH +: WIDTH]
- overflow  out  CHANNELS  channel i saturated during last window
- valid  out  1  one-cycle pulse: frequency/overflow just updated

## Operation
- Per channel: 2-flop synchronizer (s1, s2) plus history flop s3. rise = s2 & ~s3; fall = ~s2 & s3.
- Edge detection is masked until 3 clk edges after rst_n deasserts. An input held high through reset produces no count.
- edge_mode is latched into an internal mode register only at window start: the first enabled cycle, and each terminal cycle. A mid-window change takes effect in the next window.
- inc[i] = edge selected by the latched mode; inc is 0 when the mode is 11.
- Gate counter gc runs 0..GATE_CYCLES-1 while enable=1. The terminal cycle is gc == GATE_CYCLES-1.
- Non-terminal cycle:
  - cnt[i] <= sat(cnt[i] + inc[i]).
  - ovf[i] is set if cnt[i] == 2^WIDTH-1 and inc[i] = 1.
- Terminal cycle:
  - frequency[i] <= sat(cnt[i] + inc[i]). An edge in the terminal cycle belongs to the closing window.
  - overflow[i] <= ovf[i] | (terminal saturation).
  - cnt[i] <= 0, ovf[i] <= 0, gc <= 0, valid <= 1.
- There is no dead time between windows: an edge in the cycle after the terminal cycle counts 1 in the new window.
- sat(): clamps at 2^WIDTH-1. The count never wraps.
- enable=0:
  - gc, cnt and ovf are held at 0 and valid = 0.
  - frequency and overflow hold their last values.
  - Synchronizers keep running.
- enable dropping mid-window aborts that window with no publish.

## Timing
- Reset values: frequency = 0, overflow = 0, valid = 0, gc = 0, cnt = 0, ovf = 0, s1/s2/s3 = 0, mode = 00.
- Reset is asynchronous: outputs reach their reset values immediately on rst_n low, including mid-window.
- Input-to-count latency: a freqin change captured at clk edge E0 increments cnt at edge E2.
- Window length is exactly GATE_CYCLES clk edges.
- First valid after enable rises: the pulse is high in the cycle following the GATE_CYCLES-th edge at which enable was sampled 1. After that, valid repeats every GATE_CYCLES cycles.
- valid is high for exactly 1 cycle. frequency and overflow are stable from the valid cycle until the next valid.
- Simultaneous events: an inc in the terminal cycle goes to the closing window; cnt still clears.
- Any input toggling at 1/2 clk or faster is undefined (sync aliasing) and is not checked.

## Test plan
- GATE_CYCLES=100, mode 00, ch0 square wave with 10-clk period, other channels idle -> every valid: frequency[0] = 10, others 0, overflow = 0, valid period = 100.
- Same stimulus, mode 10 -> frequency[0] = 20.
- Mode changed 00->10 at gc = 50 -> that window reports 10, the next reports 20.
- WIDTH=4, ch0 period 4 clk (25 rising edges/window) -> frequency[0] = 15, overflow[0] = 1. Then period 20 -> next window 5, overflow[0] = 0.
- ch1 held high across reset release with enable=1 -> first window frequency[1] = 0.
- enable low at gc = 60, high again 30 cycles later -> no valid during the gap, outputs hold their prior values; next valid exactly 100 cycles after re-enable.
- rst_n pulsed low mid-window -> frequency, overflow and valid go to 0 immediately. After release, the first valid occurs 100 cycles after the first enabled edge.
